// File: rtl/epcs_rx_comma_aligner.sv
// epcs_rx_comma_aligner
//   Receive word aligner between a SERDES EPCS lane and the 8b/10b decoder.
//   Hunts for K28.5 commas at any of the 10 bit offsets of a sliding 20-bit
//   window, locks after LOCK_CNT hits at one offset, drops sync after LOSS_CNT
//   commas seen at a different offset, and emits aligned symbols while locked.
//   Single clock domain (EPCS_RX_CLK).
//
// Ports
//   EPCS_RX_CLK      in   lane receive clock
//   EPCS_RX_RESET_N  in   asynchronous active-low reset
//   RX_DATA_IN[9:0]  in   raw lane word, bit0 = first bit on the line
//   RX_VAL_IN        in   RX_DATA_IN valid this cycle
//   RX_IDLE_IN       in   electrical idle from the SERDES
//   REALIGN          in   one-cycle request to drop sync and re-search
//   RX_DATA_OUT[9:0] out  aligned symbol (held when RX_VAL_OUT=0)
//   RX_VAL_OUT       out  RX_DATA_OUT valid
//   RX_COMMA         out  RX_DATA_OUT is K28.5 (either disparity)
//   SYNC_STATUS      out  1 while locked
//   ALIGN_OFFSET[3:0]out  current candidate / locked bit offset 0..9
//   LOSS_EVENTS[7:0] out  saturating count of lock exits (REALIGN excluded)
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_LOS   | no alignment; first comma seen picks the candidate offset
// ST_ACQ   | candidate offset chosen; counting consecutive hits to LOCK_CNT
// ST_LOCK  | aligned; symbols emitted; counting wrong-offset commas to LOSS_CNT

module epcs_rx_comma_aligner #(
    parameter int LOCK_CNT = 3,
    parameter int LOSS_CNT = 4
) (
    input  logic       EPCS_RX_CLK,
    input  logic       EPCS_RX_RESET_N,
    input  logic [9:0] RX_DATA_IN,
    input  logic       RX_VAL_IN,
    input  logic       RX_IDLE_IN,
    input  logic       REALIGN,
    output logic [9:0] RX_DATA_OUT,
    output logic       RX_VAL_OUT,
    output logic       RX_COMMA,
    output logic       SYNC_STATUS,
    output logic [3:0] ALIGN_OFFSET,
    output logic [7:0] LOSS_EVENTS
);

    localparam logic [9:0] K28_5_NEG = 10'h17C;
    localparam logic [9:0] K28_5_POS = 10'h283;

    typedef enum logic [1:0] {
        ST_LOS  = 2'd0,
        ST_ACQ  = 2'd1,
        ST_LOCK = 2'd2
    } state_t;

    state_t      state, state_n;
    logic [3:0]  offset, offset_n;
    logic [3:0]  acq_cnt, acq_cnt_n;
    logic [3:0]  miss_cnt, miss_cnt_n;
    logic [9:0]  prev;
    logic [7:0]  loss_events;

    logic [19:0] window;
    logic [9:0]  cand [10];
    logic [9:0]  match;
    logic        any_match;
    logic [3:0]  first_k;
    logic        hit;
    logic        loss_inc;
    logic        out_valid_n;
    logic [9:0]  cand_n;

    function automatic logic is_comma(input logic [9:0] c);
        return (c == K28_5_NEG) || (c == K28_5_POS);
    endfunction

    // Older word sits in the low half so candidate k starts k bits into prev.
    assign window = {RX_DATA_IN, prev};

    always_comb begin
        match   = '0;
        first_k = 4'd0;
        for (int k = 0; k < 10; k++) begin
            cand[k]  = window[k +: 10];
            match[k] = is_comma(window[k +: 10]);
        end
        // Scan downward so the lowest matching offset is the one kept.
        for (int k = 9; k >= 0; k--) begin
            if (match[k]) first_k = 4'(k);
        end
    end

    assign any_match = |match;
    assign hit       = match[offset];

    always_comb begin
        state_n    = state;
        offset_n   = offset;
        acq_cnt_n  = acq_cnt;
        miss_cnt_n = miss_cnt;
        loss_inc   = 1'b0;

        if (REALIGN || RX_IDLE_IN) begin
            // Forced drop wins over anything the data would have done.
            state_n    = ST_LOS;
            acq_cnt_n  = 4'd0;
            miss_cnt_n = 4'd0;
            loss_inc   = (state == ST_LOCK) && !REALIGN;
        end else if (RX_VAL_IN) begin
            unique case (state)
                ST_LOS: begin
                    if (any_match) begin
                        offset_n   = first_k;
                        acq_cnt_n  = 4'd1;
                        miss_cnt_n = 4'd0;
                        state_n    = (LOCK_CNT <= 1) ? ST_LOCK : ST_ACQ;
                    end
                end
                ST_ACQ: begin
                    if (hit) begin
                        acq_cnt_n = acq_cnt + 4'd1;
                        if ({1'b0, acq_cnt} + 5'd1 >= 5'(LOCK_CNT)) begin
                            state_n    = ST_LOCK;
                            miss_cnt_n = 4'd0;
                        end
                    end else if (any_match) begin
                        offset_n  = first_k;
                        acq_cnt_n = 4'd1;
                    end
                end
                ST_LOCK: begin
                    if (hit) begin
                        miss_cnt_n = 4'd0;
                    end else if (any_match) begin
                        miss_cnt_n = miss_cnt + 4'd1;
                        if ({1'b0, miss_cnt} + 5'd1 >= 5'(LOSS_CNT)) begin
                            state_n    = ST_LOS;
                            miss_cnt_n = 4'd0;
                            acq_cnt_n  = 4'd0;
                            loss_inc   = 1'b1;
                        end
                    end
                end
                default: state_n = ST_LOS;
            endcase
        end

        // Output decision uses the post-update state so the word that
        // completes lock is emitted and the word that breaks it is not.
        out_valid_n = RX_VAL_IN && !REALIGN && !RX_IDLE_IN && (state_n == ST_LOCK);
        cand_n      = cand[offset_n];
    end

    always_ff @(posedge EPCS_RX_CLK or negedge EPCS_RX_RESET_N) begin
        if (!EPCS_RX_RESET_N) begin
            state       <= ST_LOS;
            offset      <= 4'd0;
            acq_cnt     <= 4'd0;
            miss_cnt    <= 4'd0;
            prev        <= 10'h000;
            loss_events <= 8'h00;
            RX_DATA_OUT <= 10'h000;
            RX_VAL_OUT  <= 1'b0;
            RX_COMMA    <= 1'b0;
        end else begin
            state    <= state_n;
            offset   <= offset_n;
            acq_cnt  <= acq_cnt_n;
            miss_cnt <= miss_cnt_n;
            if (RX_VAL_IN) prev <= RX_DATA_IN;
            if (loss_inc && (loss_events != 8'hFF)) loss_events <= loss_events + 8'd1;
            RX_VAL_OUT <= out_valid_n;
            RX_COMMA   <= out_valid_n && is_comma(cand_n);
            if (out_valid_n) RX_DATA_OUT <= cand_n;
        end
    end

    assign SYNC_STATUS  = (state == ST_LOCK);
    assign ALIGN_OFFSET = offset;
    assign LOSS_EVENTS  = loss_events;

endmodule

// File: tb/tb_epcs_rx_comma_aligner.sv
// tb_epcs_rx_comma_aligner
//   Drives two aligners (LOCK_CNT=3 and LOCK_CNT=1, LOSS_CNT=4) with the same
//   lane stream and compares every output each cycle against a behavioural
//   model built from the alignment rules, plus a few directed constant checks.

module tb_epcs_rx_comma_aligner;

    localparam int M_LOS  = 0;
    localparam int M_ACQ  = 1;
    localparam int M_LOCK = 2;
    localparam int LOSS_N = 4;

    logic       clk_sys = 1'b0;
    logic       rst_n;
    logic [9:0] din;
    logic       val, idle, realign;

    logic [9:0] a_data, b_data;
    logic       a_val, b_val, a_comma, b_comma, a_sync, b_sync;
    logic [3:0] a_off, b_off;
    logic [7:0] a_loss, b_loss;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_sys = ~clk_sys;

    epcs_rx_comma_aligner #(.LOCK_CNT(3), .LOSS_CNT(LOSS_N)) u_dut (
        .EPCS_RX_CLK(clk_sys), .EPCS_RX_RESET_N(rst_n),
        .RX_DATA_IN(din), .RX_VAL_IN(val), .RX_IDLE_IN(idle), .REALIGN(realign),
        .RX_DATA_OUT(a_data), .RX_VAL_OUT(a_val), .RX_COMMA(a_comma),
        .SYNC_STATUS(a_sync), .ALIGN_OFFSET(a_off), .LOSS_EVENTS(a_loss)
    );

    epcs_rx_comma_aligner #(.LOCK_CNT(1), .LOSS_CNT(LOSS_N)) u_dut_lc1 (
        .EPCS_RX_CLK(clk_sys), .EPCS_RX_RESET_N(rst_n),
        .RX_DATA_IN(din), .RX_VAL_IN(val), .RX_IDLE_IN(idle), .REALIGN(realign),
        .RX_DATA_OUT(b_data), .RX_VAL_OUT(b_val), .RX_COMMA(b_comma),
        .SYNC_STATUS(b_sync), .ALIGN_OFFSET(b_off), .LOSS_EVENTS(b_loss)
    );

    // ---------------- reference model ----------------
    int        m_state [2];
    int        m_off   [2];
    int        m_acq   [2];
    int        m_miss  [2];
    int        m_loss  [2];
    bit [9:0]  m_prev  [2];
    bit [9:0]  e_data  [2];
    bit        e_val   [2];
    bit        e_comma [2];
    int        lock_of [2] = '{3, 1};

    function automatic bit is_k(input bit [9:0] c);
        return (c == 10'h17C) || (c == 10'h283);
    endfunction

    function automatic bit [9:0] cand_at(input bit [19:0] w, input int k);
        bit [19:0] t;
        t = w >> k;
        return t[9:0];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_state[i] = M_LOS; m_off[i] = 0; m_acq[i] = 0; m_miss[i] = 0;
            m_loss[i] = 0; m_prev[i] = '0; e_data[i] = '0; e_val[i] = 0; e_comma[i] = 0;
        end
    endtask

    task automatic model_step(input int i, input bit [9:0] d, input bit v,
                              input bit id, input bit ra);
        bit [19:0] w;
        int        first;
        bit        hit;
        w = {d, m_prev[i]};
        first = -1;
        for (int k = 0; k < 10; k++)
            if (first < 0 && is_k(cand_at(w, k))) first = k;
        hit = is_k(cand_at(w, m_off[i]));
        e_val[i] = 0;
        e_comma[i] = 0;
        if (id || ra) begin
            if (m_state[i] == M_LOCK && !ra && m_loss[i] < 255) m_loss[i]++;
            m_state[i] = M_LOS; m_acq[i] = 0; m_miss[i] = 0;
        end else if (v) begin
            if (m_state[i] == M_LOS) begin
                if (first >= 0) begin
                    m_off[i] = first; m_acq[i] = 1; m_miss[i] = 0;
                    m_state[i] = (m_acq[i] >= lock_of[i]) ? M_LOCK : M_ACQ;
                end
            end else if (m_state[i] == M_ACQ) begin
                if (hit) begin
                    m_acq[i]++;
                    if (m_acq[i] >= lock_of[i]) begin m_state[i] = M_LOCK; m_miss[i] = 0; end
                end else if (first >= 0) begin
                    m_off[i] = first; m_acq[i] = 1;
                end
            end else begin
                if (hit) m_miss[i] = 0;
                else if (first >= 0) begin
                    m_miss[i]++;
                    if (m_miss[i] >= LOSS_N) begin
                        m_state[i] = M_LOS; m_miss[i] = 0; m_acq[i] = 0;
                        if (m_loss[i] < 255) m_loss[i]++;
                    end
                end
            end
            if (m_state[i] == M_LOCK) begin
                e_val[i]   = 1;
                e_data[i]  = cand_at(w, m_off[i]);
                e_comma[i] = is_k(e_data[i]);
            end
        end
        if (v) m_prev[i] = d;
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_outs();
        chk("a.val",   int'(a_val),   int'(e_val[0]));
        chk("a.data",  int'(a_data),  int'(e_data[0]));
        chk("a.comma", int'(a_comma), int'(e_comma[0]));
        chk("a.sync",  int'(a_sync),  (m_state[0] == M_LOCK) ? 1 : 0);
        chk("a.off",   int'(a_off),   m_off[0]);
        chk("a.loss",  int'(a_loss),  m_loss[0]);
        chk("b.val",   int'(b_val),   int'(e_val[1]));
        chk("b.data",  int'(b_data),  int'(e_data[1]));
        chk("b.comma", int'(b_comma), int'(e_comma[1]));
        chk("b.sync",  int'(b_sync),  (m_state[1] == M_LOCK) ? 1 : 0);
        chk("b.off",   int'(b_off),   m_off[1]);
        chk("b.loss",  int'(b_loss),  m_loss[1]);
    endtask

    task automatic cycle(input bit [9:0] d, input bit v, input bit id, input bit ra);
        din = d; val = v; idle = id; realign = ra;
        for (int i = 0; i < 2; i++) model_step(i, d, v, id, ra);
        @(posedge clk_sys);
        #1;
        check_outs();
    endtask

    // ---------------- serial stream source ----------------
    bit       bitq [$];
    bit [9:0] pattern [4] = '{10'h17C, 10'h289, 10'h283, 10'h2B6};
    int       pat_idx = 0;

    task automatic push_sym(input bit [9:0] s);
        for (int b = 0; b < 10; b++) bitq.push_back(s[b]);
    endtask

    task automatic push_junk(input int n, input bit rnd);
        for (int b = 0; b < n; b++) bitq.push_back(rnd ? 1'($urandom_range(0, 1)) : 1'(b % 2));
    endtask

    task automatic next_word(output bit [9:0] w);
        while (bitq.size() < 10) begin
            push_sym(pattern[pat_idx]);
            pat_idx = (pat_idx + 1) % 4;
        end
        for (int b = 0; b < 10; b++) w[b] = bitq.pop_front();
    endtask

    task automatic feed(input int n);
        bit [9:0] w;
        for (int j = 0; j < n; j++) begin
            next_word(w);
            cycle(w, 1, 0, 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit [9:0] w;
        rst_n = 1'b0; din = '0; val = 0; idle = 0; realign = 0;
        model_reset();
        #12;
        check_outs();
        rst_n = 1'b1;

        // Stream 3 bits late: third comma word locks at offset 3.
        push_junk(3, 0);
        feed(6);
        chk("t2.sync",  int'(a_sync),  1);
        chk("t2.off",   int'(a_off),   3);
        chk("t2.data",  int'(a_data),  'h17C);
        chk("t2.comma", int'(a_comma), 1);
        feed(1);
        chk("t2.dword", int'(a_data),  'h289);
        feed(4);

        // Re-shift to offset 7: lose sync, then relock.
        push_junk(4, 0);
        feed(20);
        chk("t3.sync", int'(a_sync), 1);
        chk("t3.off",  int'(a_off),  7);
        chk("t3.loss", int'(a_loss), 1);

        // Idle, realign, both.
        next_word(w); cycle(w, 1, 1, 0);
        chk("t4.idle_sync", int'(a_sync), 0);
        chk("t4.idle_loss", int'(a_loss), 2);
        feed(12);
        next_word(w); cycle(w, 1, 0, 1);
        chk("t4.ra_sync", int'(a_sync), 0);
        chk("t4.ra_loss", int'(a_loss), 2);
        feed(12);
        next_word(w); cycle(w, 1, 1, 1);
        chk("t4.both_loss", int'(a_loss), 2);
        feed(12);

        // Valid toggling on an offset-5 stream.
        next_word(w); cycle(w, 1, 0, 1);
        push_junk(8, 0);
        for (int j = 0; j < 40; j++) begin
            if (j % 2 == 0) begin next_word(w); cycle(w, 1, 0, 0); end
            else cycle(10'($urandom), 0, 0, 0);
        end
        chk("t5.sync", int'(a_sync), 1);
        chk("t5.off",  int'(a_off),  5);

        // Async reset while locked.
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        chk("t1.val",  int'(a_val),  0);
        chk("t1.sync", int'(a_sync), 0);
        chk("t1.data", int'(a_data), 0);
        chk("t1.loss", int'(a_loss), 0);
        chk("t1.boff", int'(b_off),  0);
        #2 rst_n = 1'b1;
        feed(16);

        // Randomized traffic.
        for (int j = 0; j < 1500; j++) begin
            bit v, id, ra;
            if ($urandom_range(0, 99) == 0) push_junk($urandom_range(1, 9), 1);
            if ($urandom_range(0, 3) != 0) next_word(w);
            else w = 10'($urandom);
            v  = ($urandom_range(0, 9) < 8);
            id = ($urandom_range(0, 49) == 0);
            ra = ($urandom_range(0, 49) == 0);
            cycle(w, v, id, ra);
        end

        // Saturation: repeated idle-forced exits from lock.
        for (int j = 0; j < 260; j++) begin
            for (int r = 0; r < 3; r++) cycle((r % 2) ? 10'h283 : 10'h17C, 1, 0, 0);
            cycle(10'h283, 1, 1, 0);
        end
        chk("t6.a_loss", int'(a_loss), 'hFF);
        chk("t6.b_loss", int'(b_loss), 'hFF);
        cycle(10'h17C, 1, 0, 0);
        chk("t6.b_lock1", int'(b_sync), 1);
        chk("t6.a_nolock", int'(a_sync), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
